reg_writeback_queue: RTL

- Write-side front end for the 32x32 register file.
- Collects writeback requests from two pipeline sources, ALU result and memory/load result, into a small in-order FIFO.
- Drains the FIFO at one write per cycle onto the register file write port (IN, INADDRESS, WRITE).
- Provides two combinational forwarding lookups so decode can see values not yet committed to the register file.

---
 rtl/reg_writeback_queue_if.sv | 34 +++
 rtl/reg_writeback_queue.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue_if.sv
// Writeback request bus between the pipeline and the register file write queue.
//
// Signals:
//   ALU_VALID/ALU_ADDR/ALU_DATA  ALU result writeback request
//   MEM_VALID/MEM_ADDR/MEM_DATA  load result writeback request
//   READY                        queue can take two requests at the next edge
//
// Modports:
//   master  pipeline side, drives requests and observes READY
//   slave   queue side, receives requests and drives READY
interface reg_writeback_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ALU_VALID;
    logic [ADDR_W-1:0] ALU_ADDR;
    logic [DATA_W-1:0] ALU_DATA;
    logic              MEM_VALID;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_DATA;
    logic              READY;

    modport master (
        output ALU_VALID, ALU_ADDR, ALU_DATA,
        output MEM_VALID, MEM_ADDR, MEM_DATA,
        input  READY
    );

    modport slave (
        input  ALU_VALID, ALU_ADDR, ALU_DATA,
        input  MEM_VALID, MEM_ADDR, MEM_DATA,
        output READY
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Register file write-side front end. Collects ALU and load writebacks into an
// in-order FIFO, drains one entry per cycle onto the register file write port,
// and offers two combinational forwarding lookups over pending writes.
//
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   req (slave)                 ALU/MEM writeback requests, READY back-pressure
//   WRITE, INADDRESS, IN        registered register file write port
//   FWD_ADDR1/2                 forwarding lookup addresses
//   FWD_HIT1/2, FWD_DATA1/2     lookup result; data is 0 on a miss
//   COUNT                       FIFO occupancy
//   OVERFLOW                    sticky: a request was dropped for lack of space
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     CLK,
    input  logic                     RESET,
    reg_writeback_queue_if.slave     req,
    output logic                     WRITE,
    output logic [ADDR_W-1:0]        INADDRESS,
    output logic [DATA_W-1:0]        IN,
    input  logic [ADDR_W-1:0]        FWD_ADDR1,
    input  logic [ADDR_W-1:0]        FWD_ADDR2,
    output logic                     FWD_HIT1,
    output logic                     FWD_HIT2,
    output logic [DATA_W-1:0]        FWD_DATA1,
    output logic [DATA_W-1:0]        FWD_DATA2,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;
    logic              ovf_q;

    logic              pop;
    logic              mem_req;
    logic              alu_req;
    logic              mem_push;
    logic              alu_push;
    logic              drop;
    logic [CW-1:0]     free_slots;
    logic [PW-1:0]     alu_slot;

    // Slot accounting: the head leaves at the same edge, so its slot is
    // already free for this edge's pushes. MEM is older and claims first.
    always_comb begin
        pop        = (count_q != '0);
        mem_req    = req.MEM_VALID && (req.MEM_ADDR != '0);
        alu_req    = req.ALU_VALID && (req.ALU_ADDR != '0);
        free_slots = CW'(DEPTH) - count_q + CW'(pop);
        mem_push   = mem_req && (free_slots != '0);
        alu_push   = alu_req && (free_slots > (mem_push ? CW'(1) : CW'(0)));
        drop       = (mem_req && !mem_push) || (alu_req && !alu_push);
        alu_slot   = wr_ptr + PW'(mem_push);
    end

    assign req.READY = (count_q <= CW'(DEPTH - 2));
    assign COUNT     = count_q;
    assign OVERFLOW  = ovf_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            wr_ptr  <= wr_ptr + PW'(mem_push) + PW'(alu_push);
            count_q <= count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; entries are only ever read once
    // COUNT says they were written, so clearing them would buy nothing.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (mem_push) begin
                addr_mem[wr_ptr] <= req.MEM_ADDR;
                data_mem[wr_ptr] <= req.MEM_DATA;
            end
            if (alu_push) begin
                addr_mem[alu_slot] <= req.ALU_ADDR;
                data_mem[alu_slot] <= req.ALU_DATA;
            end
        end
    end

    // Register file write port: one single-cycle pulse per popped entry.
    // Address/data hold their last value while idle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
        end else if (pop) begin
            WRITE     <= 1'b1;
            INADDRESS <= addr_mem[rd_ptr];
            IN        <= data_mem[rd_ptr];
        end else begin
            WRITE     <= 1'b0;
        end
    end

    // Forwarding: walk candidates oldest to youngest (output register, then
    // head..tail) so a later match overwrites an earlier one.
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        FWD_HIT1  = 1'b0;
        FWD_HIT2  = 1'b0;
        FWD_DATA1 = '0;
        FWD_DATA2 = '0;
        if (WRITE) begin
            if (INADDRESS == FWD_ADDR1) begin
                FWD_HIT1  = 1'b1;
                FWD_DATA1 = IN;
            end
            if (INADDRESS == FWD_ADDR2) begin
                FWD_HIT2  = 1'b1;
                FWD_DATA2 = IN;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (addr_mem[rd_ptr + PW'(i)] == FWD_ADDR1) begin
                    FWD_HIT1  = 1'b1;
                    FWD_DATA1 = data_mem[rd_ptr + PW'(i)];
                end
                if (addr_mem[rd_ptr + PW'(i)] == FWD_ADDR2) begin
                    FWD_HIT2  = 1'b1;
                    FWD_DATA2 = data_mem[rd_ptr + PW'(i)];
                end
            end
        end
        // x0 is never written, so it can never be pending.
        if (FWD_ADDR1 == '0) begin
            FWD_HIT1  = 1'b0;
            FWD_DATA1 = '0;
        end
        if (FWD_ADDR2 == '0) begin
            FWD_HIT2  = 1'b0;
            FWD_DATA2 = '0;
        end
    end
endmodule
